// File: rtl/arith_pkg.sv
// Shared constants and types for the arithmetic result packer.
package arith_pkg;

  localparam int DATA_W  = 4;
  localparam int NIBBLES = 4;
  localparam int PACK_W  = DATA_W * NIBBLES;
  localparam int CNT_W   = 3;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } pack_state_t;

  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic [PACK_W-1:0] data;
  } pack_word_t;

  // Number of nibbles already held in the pack register for a given state.
  function automatic logic [CNT_W-1:0] held_nibbles(input pack_state_t s);
    return {1'b0, s};
  endfunction

endpackage

// File: rtl/arith_result_packer_if.sv
// Result input stream and packed-word output handshake of the packer.
interface arith_result_packer_if import arith_pkg::*;;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [PACK_W-1:0] out_data;
  logic [CNT_W-1:0]  out_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  out_valid, out_data, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output out_valid, out_data, out_count
  );

endinterface

// File: rtl/arith_sync_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO succeeds only when a pop
// happens in the same cycle.
module arith_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    level_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (level_r == {LW{1'b0}});
  assign full      = (level_r == LW'(DEPTH));
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);
  assign pop_data  = mem_r[rd_ptr_r];
  assign level     = level_r;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

endmodule

// File: rtl/arith_result_packer.sv
// Packs 4-bit decrement results into 16-bit words, buffers them in a FIFO and
// counts 4'hF (underflow wrap) results.
module arith_result_packer import arith_pkg::*; #(
  parameter int FIFO_DEPTH = 4,
  parameter int WRAP_W     = 8
) (
  input  logic                        clk,
  input  logic                        rstn,
  arith_result_packer_if.slave        bus,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [WRAP_W-1:0]           wrap_cnt,
  output logic                        overflow
);

  localparam int WORD_W = $bits(pack_word_t);

  pack_state_t       state_r;
  pack_state_t       state_nxt_s;
  logic [PACK_W-1:0] pack_r;
  logic [PACK_W-1:0] pack_nxt_s;
  logic [PACK_W-1:0] merged_s;
  logic [CNT_W-1:0]  nib_idx_s;
  logic              push_s;
  pack_word_t        push_word_s;
  logic [WORD_W-1:0] head_s;
  pack_word_t        head_word_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              pop_s;
  logic              wrap_hit_s;
  logic [WRAP_W-1:0] wrap_cnt_r;
  logic              overflow_r;

  // Pack next-state: merge the incoming nibble, decide on a push.
  always_comb begin
    nib_idx_s   = held_nibbles(state_r);
    state_nxt_s = state_r;
    pack_nxt_s  = pack_r;
    push_s      = 1'b0;
    push_word_s = {WORD_W{1'b0}};
    // Unfilled nibbles of pack_r are zero, so OR-ing the new nibble is exact.
    merged_s    = pack_r | (PACK_W'(bus.in_data) << (DATA_W * int'(nib_idx_s)));
    if (bus.in_valid) begin
      if ((state_r == P3) || bus.flush) begin
        push_s            = 1'b1;
        push_word_s.count = nib_idx_s + CNT_W'(1);
        push_word_s.data  = merged_s;
        state_nxt_s       = P0;
        pack_nxt_s        = {PACK_W{1'b0}};
      end else begin
        state_nxt_s = pack_state_t'(state_r + 2'd1);
        pack_nxt_s  = merged_s;
      end
    end else if (bus.flush && (state_r != P0)) begin
      push_s            = 1'b1;
      push_word_s.count = nib_idx_s;
      push_word_s.data  = pack_r;
      state_nxt_s       = P0;
      pack_nxt_s        = {PACK_W{1'b0}};
    end else begin
      state_nxt_s = state_r;
      pack_nxt_s  = pack_r;
    end
  end

  assign pop_s      = bus.out_ready && !fifo_empty_s;
  assign wrap_hit_s = bus.in_valid && (bus.in_data == {DATA_W{1'b1}}) &&
                      (wrap_cnt_r != {WRAP_W{1'b1}});

  // Pack state, wrap counter and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r    <= P0;
      pack_r     <= {PACK_W{1'b0}};
      wrap_cnt_r <= {WRAP_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      pack_r  <= pack_nxt_s;
      if (wrap_hit_s) begin
        wrap_cnt_r <= wrap_cnt_r + WRAP_W'(1);
      end
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  arith_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push_s),
    .push_data (push_word_s),
    .pop       (bus.out_ready),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level)
  );

  assign head_word_s   = head_s;
  assign bus.out_valid = !fifo_empty_s;
  assign bus.out_data  = head_word_s.data;
  assign bus.out_count = head_word_s.count;
  assign wrap_cnt      = wrap_cnt_r;
  assign overflow      = overflow_r;

endmodule

// File: tb/tb_arith_result_packer.sv
// Directed scoreboard bench for arith_result_packer.
module tb_arith_result_packer;
  import arith_pkg::*;

  logic       clk;
  logic       rstn;
  logic [2:0] fifo_level;
  logic [7:0] wrap_cnt;
  logic       overflow;
  int         errors;
  int         checks;
  pack_word_t exp_q[$];

  arith_result_packer_if bus();

  arith_result_packer #(.FIFO_DEPTH(4), .WRAP_W(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .fifo_level (fifo_level),
    .wrap_cnt   (wrap_cnt),
    .overflow   (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d, input logic f);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.flush    = f;
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic expect_word(input logic [2:0] c, input logic [15:0] d);
    pack_word_t w;
    w.count = c;
    w.data  = d;
    exp_q.push_back(w);
  endtask

  task automatic wait_empty(input int budget);
    for (int i = 0; i < budget && fifo_level != 3'd0; i++) begin
      tick();
    end
    check("drain_level", 32'(fifo_level), 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_out_count"}, 32'(bus.out_count), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_wrap"}, 32'(wrap_cnt), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #2;
    check_zero_outputs("reset");
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  // Monitor: compare every accepted head word against the scoreboard.
  initial begin : monitor
    pack_word_t e;
    forever begin
      @(negedge clk);
      if (rstn && bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %0h count %0d expected none",
                   bus.out_data, bus.out_count);
        end else begin
          e = exp_q.pop_front();
          check("word_data", 32'(bus.out_data), 32'(e.data));
          check("word_count", 32'(bus.out_count), 32'(e.count));
        end
      end
    end
  end

  initial begin : stimulus
    logic [3:0] nib;
    errors        = 0;
    checks        = 0;
    rstn          = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 4'h0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    #12;
    check_zero_outputs("por");
    @(negedge clk);
    rstn = 1'b1;
    tick();

    // Full word, single-cycle valid
    bus.out_ready = 1'b1;
    send(4'h1, 1'b0);
    send(4'h2, 1'b0);
    send(4'h3, 1'b0);
    check("no_early_valid", 32'(bus.out_valid), 32'd0);
    expect_word(3'd4, 16'h4321);
    send(4'h4, 1'b0);
    check("full_valid", 32'(bus.out_valid), 32'd1);
    check("full_level", 32'(fifo_level), 32'd1);
    tick();
    check("full_valid_drop", 32'(bus.out_valid), 32'd0);

    // Partial flush, then flush in P0 produces nothing
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    expect_word(3'd2, 16'h00BA);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("partial_valid", 32'(bus.out_valid), 32'd1);
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    check("p0_flush_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("p0_flush_level", 32'(fifo_level), 32'd0);

    // Flush together with data, and a one-nibble flushed word afterwards
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    send(4'h7, 1'b0);
    expect_word(3'd4, 16'h8765);
    send(4'h8, 1'b1);
    check("flush_data_level", 32'(fifo_level), 32'd1);
    tick();
    check("flush_data_level_after", 32'(fifo_level), 32'd0);
    expect_word(3'd1, 16'h0009);
    send(4'h9, 1'b1);
    tick();
    check("no_overflow_yet", 32'(overflow), 32'd0);

    // Overflow: five words into a four-deep FIFO with no consumer
    bus.out_ready = 1'b0;
    for (int w = 1; w <= 5; w++) begin
      nib = 4'(w);
      if (w <= 4) expect_word(3'd4, {nib, nib, nib, nib});
      for (int n = 0; n < 4; n++) send(nib, 1'b0);
    end
    check("ovf_level", 32'(fifo_level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_head_data", 32'(bus.out_data), 32'h1111);
    check("ovf_head_count", 32'(bus.out_count), 32'd4);
    bus.out_ready = 1'b1;
    wait_empty(20);
    check("ovf_queue_empty", 32'(exp_q.size()), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO with simultaneous push and pop
    bus.out_ready = 1'b0;
    do_reset();
    for (int w = 6; w <= 9; w++) begin
      nib = 4'(w);
      expect_word(3'd4, {nib, nib, nib, nib});
      for (int n = 0; n < 4; n++) send(nib, 1'b0);
    end
    check("pp_full_level", 32'(fifo_level), 32'd4);
    expect_word(3'd4, 16'hAAAA);
    send(4'hA, 1'b0);
    send(4'hA, 1'b0);
    send(4'hA, 1'b0);
    bus.out_ready = 1'b1;
    send(4'hA, 1'b0);
    check("pp_level", 32'(fifo_level), 32'd4);
    check("pp_overflow", 32'(overflow), 32'd0);
    wait_empty(20);

    // Wrap counter saturation with 300 accepted 4'hF results
    for (int i = 0; i < 300; i++) begin
      if (i % 4 == 3) expect_word(3'd4, 16'hFFFF);
      send(4'hF, 1'b0);
      if (i == 15) check("wrap_16", 32'(wrap_cnt), 32'd16);
    end
    check("wrap_sat", 32'(wrap_cnt), 32'hFF);
    wait_empty(10);

    // Asynchronous reset with a buffered word and a partial word
    bus.out_ready = 1'b0;
    for (int n = 1; n <= 4; n++) send(4'(n), 1'b0);
    send(4'h5, 1'b0);
    send(4'h6, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    check_zero_outputs("async");
    @(negedge clk);
    rstn = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    tick();
    tick();
    check("post_reset_valid", 32'(bus.out_valid), 32'd0);
    check("post_reset_level", 32'(fifo_level), 32'd0);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
